// File: rtl/horizontal_fifo_ctrl_if.sv
// Control bundle between the stage control FSM (master) and the horizontal
// FIFO sequencer (slave): run request/config in, lane modes and status out.
interface horizontal_fifo_ctrl_if #(
   parameter int FRAME_W = 11
);
   logic               start;
   logic [FRAME_W-1:0] num_frames;
   logic               abort;
   logic [7:0]         mode_bus;
   logic [1:0]         comm_sel;
   logic               busy;
   logic               out_valid;
   logic               done;

   modport master (
      output start, num_frames, abort,
      input  mode_bus, comm_sel, busy, out_valid, done
   );

   modport slave (
      input  start, num_frames, abort,
      output mode_bus, comm_sel, busy, out_valid, done
   );
endinterface

// File: rtl/horizontal_fifo_ctrl.sv
// Sequences the four-lane 0/4/8/12 delay FIFO bank and commutator in a rotating
// 16-cycle pattern for N frames, drains the 12-deep FIFOs, then pulses done.
module horizontal_fifo_ctrl #(
   parameter int FRAME_W = 11
) (
   input  logic                    clk,
   input  logic                    rst_n,
   horizontal_fifo_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [3:0] CYC_LAST   = 4'd15;
   localparam logic [3:0] DRAIN_LAST = 4'd11;
   localparam logic [3:0] FILL_FULL  = 4'd12;

   state_t             state_reg,  state_next;
   logic [3:0]         cyc_reg,    cyc_next;
   logic [FRAME_W-1:0] frm_reg,    frm_next;
   logic [FRAME_W-1:0] frames_reg, frames_next;
   logic [3:0]         fill_reg,   fill_next;

   logic [7:0]         mode_reg,   mode_next;
   logic [1:0]         comm_reg,   comm_next;
   logic               busy_reg,   busy_next;
   logic               valid_reg,  valid_next;
   logic               done_reg,   done_next;

   logic [1:0]         grp_next;
   logic [7:0]         mode_rot;
   logic               run_active;

   assign grp_next = cyc_next[3:2];

   // Lane k delay select is (k + grp) mod 4; 2-bit addition wraps naturally.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign mode_rot[2*gi +: 2] = 2'(gi) + grp_next;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         cyc_reg    <= '0;
         frm_reg    <= '0;
         frames_reg <= '0;
         fill_reg   <= '0;
         mode_reg   <= '0;
         comm_reg   <= '0;
         busy_reg   <= 1'b0;
         valid_reg  <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cyc_reg    <= cyc_next;
         frm_reg    <= frm_next;
         frames_reg <= frames_next;
         fill_reg   <= fill_next;
         mode_reg   <= mode_next;
         comm_reg   <= comm_next;
         busy_reg   <= busy_next;
         valid_reg  <= valid_next;
         done_reg   <= done_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cyc_next    = cyc_reg;
      frm_next    = frm_reg;
      frames_next = frames_reg;
      fill_next   = fill_reg;
      done_next   = 1'b0;

      if (bus.abort) begin
         state_next = ST_IDLE;
         cyc_next   = '0;
         frm_next   = '0;
         fill_next  = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.start && (bus.num_frames != '0)) begin
                  state_next  = ST_RUN;
                  frames_next = bus.num_frames;
                  cyc_next    = '0;
                  frm_next    = '0;
                  fill_next   = '0;
               end
            end

            ST_RUN: begin
               cyc_next  = cyc_reg + 4'd1;
               // Fill only tracks RUN cycles and saturates once the deepest FIFO is primed.
               fill_next = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 4'd1;
               if (cyc_reg == CYC_LAST) begin
                  frm_next = frm_reg + FRAME_W'(1);
                  if (frm_reg == frames_reg - FRAME_W'(1)) begin
                     state_next = ST_DRAIN;
                  end
               end
            end

            ST_DRAIN: begin
               // DRAIN always begins at cyc 0, so cyc doubles as the drain timer.
               cyc_next = cyc_reg + 4'd1;
               if (cyc_reg == DRAIN_LAST) begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
                  cyc_next   = '0;
                  frm_next   = '0;
                  fill_next  = '0;
               end
            end

            default: begin
               state_next = ST_IDLE;
               cyc_next   = '0;
               frm_next   = '0;
               fill_next  = '0;
            end
         endcase
      end

      run_active = (state_next != ST_IDLE);
      busy_next  = run_active;
      mode_next  = run_active ? mode_rot : 8'd0;
      comm_next  = run_active ? grp_next : 2'd0;
      valid_next = run_active && (fill_next == FILL_FULL);
   end

   assign bus.mode_bus  = mode_reg;
   assign bus.comm_sel  = comm_reg;
   assign bus.busy      = busy_reg;
   assign bus.out_valid = valid_reg;
   assign bus.done      = done_reg;

endmodule

// File: tb/tb_horizontal_fifo_ctrl.sv
// Self-checking bench: table vectors for a single-frame run, directed corner
// sequences, and random traffic against a timeline-based reference model.
module tb_horizontal_fifo_ctrl;

   localparam int FW = 11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   horizontal_fifo_ctrl_if #(.FRAME_W(FW)) bus ();

   horizontal_fifo_ctrl #(.FRAME_W(FW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cycle    = 0;
   int runs     = 0;

   // Reference model: position k within a run timeline (cycle k after the accepted start edge).
   bit m_active = 1'b0;
   int m_k      = 0;
   int m_n      = 0;

   typedef struct {
      logic          start;
      logic [FW-1:0] nf;
      logic          abort;
      logic [7:0]    mode;
      logic [1:0]    comm;
      logic          busy;
      logic          valid;
      logic          done;
   } vec_t;

   vec_t tbl [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
   endtask

   function automatic void model_reset();
      m_active = 1'b0;
      m_k = 0;
      m_n = 0;
   endfunction

   function automatic void model_edge(input logic s, input logic [FW-1:0] nf, input logic ab);
      bit idle;
      idle = !m_active || (m_k >= 16*m_n + 13);
      if (ab) m_active = 1'b0;
      else if (idle) begin
         if (s && nf != 0) begin
            m_active = 1'b1;
            m_n = int'(nf);
            m_k = 1;
         end else if (m_active) m_k++;
      end else m_k++;
   endfunction

   function automatic logic [12:0] model_vec();
      logic [7:0] m;
      logic [1:0] g;
      logic b, v, d;
      int c;
      m = '0; g = '0; b = 1'b0; v = 1'b0; d = 1'b0;
      if (m_active) begin
         if (m_k >= 1 && m_k <= 16*m_n + 12) begin
            b = 1'b1;
            c = (m_k - 1) % 16;
            g = 2'(c / 4);
            for (int l = 0; l < 4; l++) m[2*l +: 2] = 2'((l + c/4) % 4);
            v = (m_k >= 13);
         end
         d = (m_k == 16*m_n + 13);
      end
      return {m, g, b, v, d};
   endfunction

   function automatic logic [12:0] dut_vec();
      return {bus.mode_bus, bus.comm_sel, bus.busy, bus.out_valid, bus.done};
   endfunction

   // Called at a negedge: drive, clock, advance model, compare after the edge settles.
   task automatic step(input logic s, input logic [FW-1:0] nf, input logic ab);
      bus.start = s;
      bus.num_frames = nf;
      bus.abort = ab;
      @(posedge clk);
      model_edge(s, nf, ab);
      @(negedge clk);
      cycle++;
      check("model", 32'(dut_vec()), 32'(model_vec()));
      if (bus.done) begin
         runs++;
         $display("run %0d done at cycle %0d (frames=%0d)", runs, cycle, m_n);
      end
   endtask

   initial begin
      logic [7:0] pat [4];
      int c, done_at, valid_cnt, done_cnt;

      bus.start = 1'b0;
      bus.num_frames = '0;
      bus.abort = 1'b0;

      pat[0] = 8'hE4; pat[1] = 8'h39; pat[2] = 8'h4E; pat[3] = 8'h93;
      for (int i = 0; i < 32; i++) begin
         c = i + 1;
         tbl[i].start = (i == 0);
         tbl[i].nf    = FW'(1);
         tbl[i].abort = 1'b0;
         tbl[i].busy  = (c <= 28);
         tbl[i].mode  = tbl[i].busy ? pat[((c-1) % 16) / 4] : 8'h00;
         tbl[i].comm  = tbl[i].busy ? 2'(((c-1) % 16) / 4) : 2'd0;
         tbl[i].valid = (c >= 13) && (c <= 28);
         tbl[i].done  = (c == 29);
      end

      // Reset then idle
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(dut_vec()), 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);
      check("idle_outputs", 32'(dut_vec()), 32'h0);
      $display("reset/idle phase complete");

      // Single frame from table
      for (int i = 0; i < 32; i++) begin
         step(tbl[i].start, tbl[i].nf, tbl[i].abort);
         check("tbl_mode",  32'(bus.mode_bus),  32'(tbl[i].mode));
         check("tbl_comm",  32'(bus.comm_sel),  32'(tbl[i].comm));
         check("tbl_busy",  32'(bus.busy),      32'(tbl[i].busy));
         check("tbl_valid", 32'(bus.out_valid), 32'(tbl[i].valid));
         check("tbl_done",  32'(bus.done),      32'(tbl[i].done));
      end

      // start with num_frames = 0 is ignored
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, '0, 1'b0);
         if (bus.busy || bus.done) done_cnt++;
      end
      check("zero_frames_ignored", 32'(done_cnt), 32'd0);

      // start pulsed mid-run does not re-latch
      done_at = -1;
      step(1'b1, FW'(2), 1'b0);
      for (int j = 1; j < 60; j++) begin
         step(j == 5, FW'(7), 1'b0);
         if (bus.done && done_at < 0) done_at = j + 1;
      end
      check("restart_ignored_done_at", 32'(done_at), 32'd45);

      // abort mid-run, then fresh start
      step(1'b1, FW'(4), 1'b0);
      for (int j = 1; j <= 22; j++) begin
         step(j == 22, FW'(1), j == 20);
         if (j == 20) check("abort_idle", 32'(dut_vec()), 32'h0);
         if (j == 22) check("after_abort_mode", 32'(bus.mode_bus), 32'hE4);
      end
      for (int j = 0; j < 30; j++) step(1'b0, '0, 1'b0);

      // async reset during DRAIN
      step(1'b1, FW'(1), 1'b0);
      for (int j = 1; j < 20; j++) step(1'b0, '0, 1'b0);
      check("in_drain_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_now", 32'(dut_vec()), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      check("async_reset_held", 32'(dut_vec()), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      done_at = -1;
      step(1'b1, FW'(1), 1'b0);
      check("post_reset_mode", 32'(bus.mode_bus), 32'hE4);
      for (int j = 1; j < 32; j++) begin
         step(1'b0, '0, 1'b0);
         if (bus.done && done_at < 0) done_at = j + 1;
      end
      check("post_reset_done_at", 32'(done_at), 32'd29);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         step(($urandom % 8) == 0, FW'($urandom_range(0, 3)), ($urandom % 40) == 0);
      end
      step(1'b0, '0, 1'b1);
      $display("random phase complete");

      // full transform
      done_at = -1; valid_cnt = 0; done_cnt = 0;
      step(1'b1, FW'(1024), 1'b0);
      for (int j = 1; j < 16410; j++) begin
         step(1'b0, '0, 1'b0);
         if (bus.out_valid) valid_cnt++;
         if (bus.done) begin
            done_cnt++;
            done_at = j + 1;
         end
      end
      check("full_valid_cycles", 32'(valid_cnt), 32'd16384);
      check("full_done_count", 32'(done_cnt), 32'd1);
      check("full_done_at", 32'(done_at), 32'd16397);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/horizontal_fifo_ctrl.md
# horizontal_fifo_ctrl

Sequencer for the four-lane horizontal delay FIFO bank in the radix-16 16384-point pipeline. Each FIFO instance selects a 0/4/8/12-cycle delay through its 2-bit `mode`; this block drives all four lane modes and the downstream commutator select in a rotating 16-cycle pattern for a programmed number of frames. It then drains the 12-cycle FIFO depth and reports completion. Sits between the stage control FSM and the datapath; it touches no data.

## Interface
- `FRAME_W`, 11: width of the frame-count configuration; 1024 frames of 16 samples per 16384-point transform.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle request to begin a run; sampled only in IDLE.
- `num_frames`  input  FRAME_W  number of 16-cycle frames to sequence; latched on accepted `start`.
- `abort`  input  1  synchronous cancel; returns to IDLE next cycle.
- `mode_bus`  output  8  lane modes, `mode_bus[2k+1:2k]` = lane k mode (0: delay0, 1: delay4, 2: delay8, 3: delay12).
- `comm_sel`  output  2  commutator select for the FIFO outputs.
- `busy`  output  1  high in RUN and DRAIN.
- `out_valid`  output  1  high while FIFO outputs carry valid samples.
- `done`  output  1  one-cycle pulse at the end of a run.

## Operation
- States: IDLE, RUN, DRAIN. All outputs are registered.
- Reset values: state IDLE, `mode_bus`=0, `comm_sel`=0, `busy`=0, `out_valid`=0, `done`=0, all counters 0.
- IDLE:
  - `start`=1 and `num_frames`≠0 → latch `num_frames`, clear counters, go to RUN.
  - `start` with `num_frames`=0 is ignored: no state change, no `done`.
- Counters:
  - `cyc[3:0]` advances every RUN/DRAIN cycle and wraps 15→0.
  - `frm` (FRAME_W bits) increments on each `cyc` wrap during RUN.
  - `grp` = `cyc[3:2]`.
- RUN/DRAIN outputs: lane k mode = (k + grp) mod 4, 2-bit wraparound; `comm_sel` = grp.
- IDLE outputs: all lane modes 0 (pass-through), `comm_sel` = 0.
- RUN → DRAIN after the cycle with `cyc`=15 and `frm`=latched−1. Exactly 16·N RUN cycles.
- DRAIN lasts exactly 12 cycles. During DRAIN, `cyc` keeps running and the rotation continues. Then go to IDLE with `done`=1 for one cycle.
- `out_valid`:
  - A 4-bit fill counter counts RUN cycles. `out_valid` rises on the 13th cycle after RUN entry.
  - It stays high through the last DRAIN cycle, for exactly 16·N cycles in total.
- `start` during RUN/DRAIN is ignored; the configuration is not re-latched.
- `abort` has priority over all other transitions in any state:
  - Next cycle: IDLE, outputs at reset values, `done` not asserted.
  - Asserting `abort` in IDLE has no effect.
- Asynchronous `rst_n` low mid-run forces reset values immediately. No `done` is produced.

## Timing
- `start` sampled at edge T → at T+1: `busy`=1, `mode_bus`=8'b11_10_01_00, `comm_sel`=0.
- The pattern advances one `cyc` step per cycle. `grp` changes every 4 cycles:
  - grp 0: lanes 0,1,2,3 = 0,1,2,3
  - grp 1: lanes 0,1,2,3 = 1,2,3,0
  - grp 2: lanes 0,1,2,3 = 2,3,0,1
  - grp 3: lanes 0,1,2,3 = 3,0,1,2
- `out_valid` is high from T+13 through T+12+16N.
- DRAIN occupies T+16N+1 … T+16N+12.
- `done`=1 and `busy`=0 at T+16N+13, with `mode_bus` back to 0.
- A new `start` is accepted at edge T+16N+13 at the earliest. This gives back-to-back runs with one IDLE cycle between them.

## Test plan
- Reset then idle: hold `rst_n`=0, release, run 20 cycles with no `start` → all outputs 0, `busy`=0.
- Single frame, `num_frames`=1, `start` at T:
  - `mode_bus` sequence 0xE4 ×4, 0x39 ×4, 0x4E ×4, 0x93 ×4, then DRAIN continuing 0xE4 ×4, 0x39 ×4, 0x4E ×4.
  - `out_valid` high T+13..T+28; `done` pulse at T+29; `busy` low at T+29.
- Full transform, `num_frames`=1024 → `out_valid` high for exactly 16384 cycles, one `done` pulse at T+16397, `comm_sel` cycles 0..3 every 16 cycles.
- Ignored requests:
  - `start` with `num_frames`=0 → stays IDLE, no `done`.
  - `start` pulsed at T+5 of a `num_frames`=2 run → run length unchanged, `done` at T+45.
- Abort and reset mid-run:
  - `abort` at T+20 of a `num_frames`=4 run → IDLE at T+21 with outputs 0, no `done`.
  - A new `start` at T+22 → fresh run, `mode_bus`=0xE4 at T+23.
- Async reset mid-DRAIN: drop `rst_n` between edges during DRAIN → outputs 0 before the next edge. After release, a new `start` behaves as in the single-frame scenario.
